// File: rtl/rx_bit_timer_if.sv
// Signal bundle between the edge detector / receive FSM (master) and rx_bit_timer (slave).
// BITS_PER_WORD must match the attached rx_bit_timer so bit_count widths agree.
interface rx_bit_timer_if #(
    parameter int BITS_PER_WORD = 8
);
    localparam int BC_W = $clog2(BITS_PER_WORD);

    logic            d_edge;
    logic            rcving;
    logic            stuff_bit;
    logic            shift_enable;
    logic            word_received;
    logic [BC_W-1:0] bit_count;
    logic            idle_err;

    modport master (
        output d_edge, rcving, stuff_bit,
        input  shift_enable, word_received, bit_count, idle_err
    );

    modport slave (
        input  d_edge, rcving, stuff_bit,
        output shift_enable, word_received, bit_count, idle_err
    );
endinterface

// File: rtl/rx_bit_timer.sv
// USB receive bit/word timer: oversampling phase tracking with edge resync, sample strobe, word counting.
// Optional idle-timeout detection is compiled in with `define RX_TIMER_IDLE_ERR_EN.
module rx_bit_timer #(
    parameter int SAMPLES_PER_BIT = 8,
    parameter int SAMPLE_POINT    = 3,
    parameter int BITS_PER_WORD   = 8,
    parameter int MAX_IDLE_BITS   = 7
) (
    input  logic clk,
    input  logic rst,
    rx_bit_timer_if.slave bus
);
    localparam int PH_W = $clog2(SAMPLES_PER_BIT);
    localparam int BC_W = $clog2(BITS_PER_WORD);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SAMPLES_PER_BIT - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_POINT);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BITS_PER_WORD - 1);

    // Elaboration-time guards against illegal parameter combinations
    if (SAMPLES_PER_BIT < 2) begin : g_bad_spb
        $error("rx_bit_timer: SAMPLES_PER_BIT must be >= 2");
    end
    if (SAMPLE_POINT < 0 || SAMPLE_POINT >= SAMPLES_PER_BIT) begin : g_bad_sp
        $error("rx_bit_timer: SAMPLE_POINT out of range");
    end
    if (BITS_PER_WORD < 2) begin : g_bad_bpw
        $error("rx_bit_timer: BITS_PER_WORD must be >= 2");
    end
    if (MAX_IDLE_BITS < 1) begin : g_bad_idle
        $error("rx_bit_timer: MAX_IDLE_BITS must be >= 1");
    end

    logic [PH_W-1:0] ph_reg, ph_next;
    logic [BC_W-1:0] bc_reg, bc_next;
    logic            word_received_reg, word_received_next;
    logic            shift_en;
    logic            counted_shift;

    always_comb begin
        shift_en      = bus.rcving && (ph_reg == PH_SAMPLE);
        counted_shift = shift_en && !bus.stuff_bit;
    end

    always_comb begin
        ph_next = ph_reg;
        if (!bus.rcving || bus.d_edge) begin
            ph_next = '0;
        end else if (ph_reg == PH_LAST) begin
            ph_next = '0;
        end else begin
            ph_next = ph_reg + 1'b1;
        end
    end

    // The word pulse comes from the register so it lands the cycle after the final counted shift
    always_comb begin
        bc_next            = bc_reg;
        word_received_next = 1'b0;
        if (!bus.rcving) begin
            bc_next = '0;
        end else if (counted_shift) begin
            if (bc_reg == BC_LAST) begin
                bc_next            = '0;
                word_received_next = 1'b1;
            end else begin
                bc_next = bc_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_reg            <= '0;
            bc_reg            <= '0;
            word_received_reg <= 1'b0;
        end else begin
            ph_reg            <= ph_next;
            bc_reg            <= bc_next;
            word_received_reg <= word_received_next;
        end
    end

`ifdef RX_TIMER_IDLE_ERR_EN
    localparam int IC_W = $clog2(MAX_IDLE_BITS + 1);
    localparam logic [IC_W-1:0] IC_MAX = IC_W'(MAX_IDLE_BITS);

    logic [IC_W-1:0] ic_reg, ic_next;
    logic            idle_err_reg, idle_err_next;
    logic            ph_wrap;

    // A wrap only counts when the phase really rolls over, not when an edge restarts it
    always_comb begin
        ph_wrap       = bus.rcving && !bus.d_edge && (ph_reg == PH_LAST);
        ic_next       = ic_reg;
        if (!bus.rcving || bus.d_edge) begin
            ic_next = '0;
        end else if (ph_wrap && (ic_reg != IC_MAX)) begin
            ic_next = ic_reg + 1'b1;
        end
        idle_err_next = bus.rcving && (idle_err_reg || (ic_next == IC_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_reg       <= '0;
            idle_err_reg <= 1'b0;
        end else begin
            ic_reg       <= ic_next;
            idle_err_reg <= idle_err_next;
        end
    end

    assign bus.idle_err = idle_err_reg;
`else
    assign bus.idle_err = 1'b0;
`endif

    assign bus.shift_enable  = shift_en;
    assign bus.word_received = word_received_reg;
    assign bus.bit_count     = bc_reg;
endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed self-checking bench for rx_bit_timer: default instance plus a 4x/16-bit parameter variant.
module tb_rx_bit_timer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rx_bit_timer_if #(.BITS_PER_WORD(8))  if1 ();
    rx_bit_timer_if #(.BITS_PER_WORD(16)) if2 ();

    rx_bit_timer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    rx_bit_timer #(
        .SAMPLES_PER_BIT (4),
        .SAMPLE_POINT    (1),
        .BITS_PER_WORD   (16),
        .MAX_IDLE_BITS   (7)
    ) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Strobes at first, first+period, ...; counted bits before cycle k, modulo word length
    function automatic int bits_before(input int k, input int first, input int period, input int nbits);
        if (k <= first) return 0;
        return (((k - first - 1) / period) + 1) % nbits;
    endfunction

    // One clean 8-bit word on the default instance, starting from ph=0, bc=0
    task automatic run_word(input string tag);
        int words;
        words = 0;
        if1.rcving = 1'b1;
        for (int k = 0; k < 64; k++) begin
            #1;
            chk($sformatf("%s_se_k%0d", tag, k), 32'(if1.shift_enable), 32'((k % 8) == 3));
            chk($sformatf("%s_bc_k%0d", tag, k), 32'(if1.bit_count), 32'(bits_before(k, 3, 8, 8)));
            chk($sformatf("%s_wr_k%0d", tag, k), 32'(if1.word_received), 32'(k == 60));
            if (if1.word_received === 1'b1) words++;
            tick();
        end
        $display("%s: words_received=%0d", tag, words);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        if1.d_edge = 1'b0; if1.rcving = 1'b0; if1.stuff_bit = 1'b0;
        if2.d_edge = 1'b0; if2.rcving = 1'b0; if2.stuff_bit = 1'b0;
        #1;
        chk("rst_se", 32'(if1.shift_enable), 32'd0);
        chk("rst_wr", 32'(if1.word_received), 32'd0);
        chk("rst_bc", 32'(if1.bit_count), 32'd0);
        chk("rst_idle", 32'(if1.idle_err), 32'd0);
        #11;
        rst = 1'b0;
        tick();
        $display("reset: done");

        // Basic timing, no edges
        run_word("basic");
        if1.rcving = 1'b0;
        tick();

        // Resync: edge at ph=6, and an edge coinciding with a strobe
        if1.rcving = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if1.d_edge = (k == 6 || k == 10);
            #1;
            chk($sformatf("resync_se_k%0d", k), 32'(if1.shift_enable), 32'(k == 3 || k == 10 || k == 14));
            chk($sformatf("resync_bc_k%0d", k), 32'(if1.bit_count),
                32'((k <= 3) ? 0 : (k <= 10) ? 1 : (k <= 14) ? 2 : 3));
            tick();
        end
        if1.d_edge = 1'b0;
        if1.rcving = 1'b0;
        tick();
        $display("resync: done");

        // Stuffed 4th bit is not counted; a stuff_bit away from a strobe is ignored
        if1.rcving = 1'b1;
        for (int k = 0; k < 70; k++) begin
            int n;
            if1.stuff_bit = (k == 20 || k == 27);
            #1;
            n = (k <= 3) ? 0 : ((k - 4) / 8 + 1);
            if (k > 27) n = n - 1;
            chk($sformatf("stuff_bc_k%0d", k), 32'(if1.bit_count), 32'(n % 8));
            chk($sformatf("stuff_wr_k%0d", k), 32'(if1.word_received), 32'(k == 68));
            tick();
        end
        if1.stuff_bit = 1'b0;
        if1.rcving = 1'b0;
        tick();
        $display("stuff: done");

        // Abort at bit_count=5, then a fresh word
        if1.rcving = 1'b1;
        for (int k = 0; k < 36; k++) tick();
        #1;
        chk("abort_bc_before", 32'(if1.bit_count), 32'd5);
        if1.rcving = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("abort_bc_%0d", k), 32'(if1.bit_count), 32'd0);
            chk($sformatf("abort_wr_%0d", k), 32'(if1.word_received), 32'd0);
            chk($sformatf("abort_se_%0d", k), 32'(if1.shift_enable), 32'd0);
            tick();
        end
        run_word("after_abort");
        if1.rcving = 1'b0;
        tick();

        // Async reset between clock edges while a strobe is active
        if1.rcving = 1'b1;
        for (int k = 0; k < 59; k++) tick();
        #1;
        chk("arst_se_before", 32'(if1.shift_enable), 32'd1);
        chk("arst_bc_before", 32'(if1.bit_count), 32'd7);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_se", 32'(if1.shift_enable), 32'd0);
        chk("arst_bc", 32'(if1.bit_count), 32'd0);
        chk("arst_wr", 32'(if1.word_received), 32'd0);
        chk("arst_idle", 32'(if1.idle_err), 32'd0);
        rst = 1'b0;
        if1.rcving = 1'b0;
        tick();
        $display("async_reset: done");

        // Parameter variant: 4 samples/bit, sample point 1, 16-bit words
        if2.rcving = 1'b1;
        for (int k = 0; k < 66; k++) begin
            #1;
            chk($sformatf("p4_se_k%0d", k), 32'(if2.shift_enable), 32'((k % 4) == 1));
            chk($sformatf("p4_bc_k%0d", k), 32'(if2.bit_count), 32'(bits_before(k, 1, 4, 16)));
            chk($sformatf("p4_wr_k%0d", k), 32'(if2.word_received), 32'(k == 62));
            tick();
        end
        if2.rcving = 1'b0;
        tick();
        $display("param_sweep: done");

        // Idle timeout: seventh wrap without an edge lands at cycle 56
        if1.rcving = 1'b1;
        for (int k = 0; k < 60; k++) begin
            #1;
`ifdef RX_TIMER_IDLE_ERR_EN
            chk($sformatf("idle_k%0d", k), 32'(if1.idle_err), 32'(k >= 56));
`else
            chk($sformatf("idle_k%0d", k), 32'(if1.idle_err), 32'd0);
`endif
            tick();
        end
        if1.rcving = 1'b0;
        tick();
        #1;
        chk("idle_clear", 32'(if1.idle_err), 32'd0);
        $display("idle: done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
Parametrised bit/word timing generator for the USB receive path; successor to the fixed 8x-oversampled, 8-bit timer.
- Tracks the oversampling phase within each bit period and resynchronises that phase on every detected data edge.
- Emits a single-cycle shift strobe at a programmable sample point.
- Counts shifted bits into words of configurable length. Stuffed bits are excluded from the count.
- Sits between the edge detector and the shift register / receive FSM.

Parameters:
- SAMPLES_PER_BIT, 8, clocks per bit period; legal range >= 2.
- SAMPLE_POINT, 3, phase value at which the bit is sampled; legal range 0..SAMPLES_PER_BIT-1.
- BITS_PER_WORD, 8, counted bits per received word; legal range >= 2.
- MAX_IDLE_BITS, 7, bit periods without an edge before idle error; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- d_edge  input  1  single-cycle pulse: transition detected on the line.
- rcving  input  1  high while a packet is being received.
- stuff_bit  input  1  qualifies the current shift_enable as a stuffed bit; that bit is not counted.
- shift_enable  output  1  one-cycle sample/shift strobe.
- word_received  output  1  registered one-cycle pulse: a full word has been counted.
- bit_count  output  $clog2(BITS_PER_WORD)  number of counted bits in the current word.
- idle_err  output  1  sticky idle-timeout flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (async, rst=1): phase counter ph=0, bit counter bc=0, word_received=0, idle_err=0. shift_enable=0 because it is decoded from ph and rcving.
- Phase counter ph (width $clog2(SAMPLES_PER_BIT)):
  - rcving=0: ph <= 0.
  - rcving=1 and d_edge=1: ph <= 0. The edge in cycle t gives ph=0 in cycle t+1.
  - Otherwise: ph <= (ph==SAMPLES_PER_BIT-1) ? 0 : ph+1.
- shift_enable = rcving && (ph==SAMPLE_POINT). This is combinational from registered state.
  - A d_edge in the same cycle does not suppress it; the edge only restarts the phase.
- Counted shift cs = shift_enable && !stuff_bit.
  - stuff_bit is ignored when shift_enable=0.
- Bit counter bc:
  - rcving=0: bc <= 0.
  - cs and bc==BITS_PER_WORD-1: bc <= 0 and word_received <= 1 (visible the cycle after the final counted shift).
  - cs otherwise: bc <= bc+1.
  - No cs: bc holds.
- word_received is 1 for exactly one cycle per completed word, and is 0 in every other cycle.
- bit_count = bc.
- Deassertion of rcving mid-word: the partial word is discarded, ph and bc are 0 on the next cycle, and no word_received is generated.
- Reassertion of rcving restarts from ph=0, bc=0. The first shift_enable falls SAMPLE_POINT cycles after ph first reaches 0, or after a d_edge restarts it.
- Back-to-back words: bc wraps with no idle cycle; the next word's first bit may be counted in the same cycle word_received is high.

Optional Feature:
- Macro: RX_TIMER_IDLE_ERR_EN.
- Defined:
  - Idle counter ic counts ph wraps (SAMPLES_PER_BIT-1 -> 0) since the last d_edge.
  - ic is cleared by d_edge or rcving=0, and saturates at MAX_IDLE_BITS.
  - When ic reaches MAX_IDLE_BITS, idle_err <= 1 and stays sticky until rcving=0 or rst.
  - Bit counting is unaffected.
- Undefined: ic is not implemented and idle_err is constant 0.

Test Plan:
- Basic timing (defaults): rst, then rcving=1 with no edges → shift_enable in the cycle where ph reaches 3 and every 8 clocks after; after 8 strobes, word_received pulses once on the following cycle; bit_count walks 0..7 then returns to 0.
- Resync: d_edge at ph=6 → ph=0 the next cycle, and the next shift_enable comes 3 cycles later rather than at the original slot.
- Stuffed bit: stuff_bit=1 on the 4th strobe → bit_count holds at 3, and word_received arrives after the 9th strobe.
- Abort: rcving drops when bit_count=5 → next cycle ph=0 and bit_count=0, with no word_received; reassert rcving → a fresh 8-bit word completes normally.
- Async reset mid-word: rst pulsed between clock edges → all outputs 0 immediately, with no clk edge required.
- Parameter sweep: SAMPLES_PER_BIT=4, SAMPLE_POINT=1, BITS_PER_WORD=16 → strobe period 4 and word_received after 16 counted strobes. With RX_TIMER_IDLE_ERR_EN and MAX_IDLE_BITS=7: 7 bit periods with no edge → idle_err=1; dropping rcving clears it.
